// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, load funct3 encodings and the
// write-back round-robin pointer encoding.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    PREF_LSU = 1'b0,
    PREF_ALU = 1'b1
  } rr_pref_e;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks the addressed byte/halfword out of the aligned
// memory word, sign/zero-extends it and flags misaligned accesses.
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data     = rdata;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data     = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign = offset[0];
      end
      F3_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_sel};
        misalign = offset[0];
      end
      // Unknown encodings are treated exactly like LW.
      default: misalign = (offset != 2'd0);
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: round-robin arbitration between the ALU/CSR and load
// result channels, feeding one registered register-file write per cycle.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [2:0]        lsu_funct3,
  input  logic [1:0]        lsu_addr_lo,
  input  logic [XLEN-1:0]   lsu_rdata,
  input  logic              stall,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retire_cnt
);

  rr_pref_e          pref_q, pref_d;
  logic              wen_q, wen_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              mis_q, mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0]   ld_data;
  logic              ld_misalign;
  logic              grant_alu, grant_lsu;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3   (lsu_funct3),
    .offset   (lsu_addr_lo),
    .rdata    (lsu_rdata),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  // A lone valid always wins; on contention the pointer decides.
  assign grant_lsu = !stall && lsu_valid && (!alu_valid || pref_q == PREF_LSU);
  assign grant_alu = !stall && alu_valid && (!lsu_valid || pref_q == PREF_ALU);
  assign lsu_ready = grant_lsu;
  assign alu_ready = grant_alu;

  always_comb begin
    pref_d  = pref_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;
    if (grant_lsu) begin
      pref_d = PREF_ALU;
      cnt_d  = cnt_q + CNT_W'(1);
      if (ld_misalign) begin
        mis_d = 1'b1;
      end else if (lsu_rd != '0) begin
        wen_d   = 1'b1;
        waddr_d = lsu_rd;
        wdata_d = ld_data;
      end
    end else if (grant_alu) begin
      pref_d = PREF_LSU;
      cnt_d  = cnt_q + CNT_W'(1);
      if (alu_rd != '0) begin
        wen_d   = 1'b1;
        waddr_d = alu_rd;
        wdata_d = alu_data;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pref_q  <= PREF_LSU;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pref_q  <= pref_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_wen       = wen_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign misalign_err = mis_q;
  assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change on the falling edge, outputs
// are sampled on the falling edge after the transfer edge.
module tb_wb_arbiter;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic [31:0] lsu_rdata;
  logic        stall;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;
  logic [63:0] retire_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .CNT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_funct3   (lsu_funct3),
    .lsu_addr_lo  (lsu_addr_lo),
    .lsu_rdata    (lsu_rdata),
    .stall        (stall),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .misalign_err (misalign_err),
    .retire_cnt   (retire_cnt)
  );

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    lsu_valid   = 1'b0;
    lsu_rd      = '0;
    lsu_funct3  = F3_LW;
    lsu_addr_lo = '0;
    lsu_rdata   = '0;
    stall       = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst       = 1'b1;
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'hA5A5_A5A5;
    cycle();
    cycle();
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b want=0", rf_wen); end
    total++; if (retire_cnt !== 64'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", retire_cnt); end
    total++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin bad++;
      $display("FAIL reset_wr got=%0d/%h want=0/00000000", rf_waddr, rf_wdata); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b want=0", misalign_err); end
    rst = 1'b0;
    idle();
    cycle();
    total++; if (retire_cnt !== 64'd0 || rf_wen !== 1'b0) begin bad++;
      $display("FAIL reset_after got cnt=%0d wen=%b want cnt=0 wen=0", retire_cnt, rf_wen); end
  endtask

  task automatic test_alu_only();
    idle();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEAD_BEEF;
    #1;
    total++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin bad++;
      $display("FAIL alu_ready got=%b/%b want=1/0", alu_ready, lsu_ready); end
    cycle();
    idle();
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin bad++;
      $display("FAIL alu_write got=%b/%0d/%h want=1/5/deadbeef", rf_wen, rf_waddr, rf_wdata); end
    total++; if (retire_cnt !== 64'd1) begin bad++; $display("FAIL alu_cnt got=%0d want=1", retire_cnt); end
    cycle();
    total++; if (rf_wen !== 1'b0 || rf_wdata !== 32'hDEAD_BEEF || rf_waddr !== 5'd5) begin bad++;
      $display("FAIL alu_hold got=%b/%0d/%h want=0/5/deadbeef", rf_wen, rf_waddr, rf_wdata); end
  endtask

  task automatic test_contention();
    logic exp_lsu [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_alu [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    idle();
    alu_valid   = 1'b1;
    alu_rd      = 5'd1;
    alu_data    = 32'h11;
    lsu_valid   = 1'b1;
    lsu_rd      = 5'd2;
    lsu_funct3  = F3_LW;
    lsu_rdata   = 32'h22;
    for (int i = 0; i < 5; i++) begin
      stall = (i == 2);
      #1;
      total++; if (lsu_ready !== exp_lsu[i] || alu_ready !== exp_alu[i]) begin bad++;
        $display("FAIL cont_ready[%0d] got lsu=%b alu=%b want lsu=%b alu=%b",
                 i, lsu_ready, alu_ready, exp_lsu[i], exp_alu[i]); end
      cycle();
      if (exp_lsu[i]) begin
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) begin bad++;
          $display("FAIL cont_write[%0d] got=%b/%0d/%h want=1/2/00000022", i, rf_wen, rf_waddr, rf_wdata); end
      end else if (exp_alu[i]) begin
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h11) begin bad++;
          $display("FAIL cont_write[%0d] got=%b/%0d/%h want=1/1/00000011", i, rf_wen, rf_waddr, rf_wdata); end
      end else begin
        total++; if (rf_wen !== 1'b0) begin bad++;
          $display("FAIL cont_stall_wen[%0d] got=%b want=0", i, rf_wen); end
      end
    end
    idle();
    total++; if (retire_cnt !== 64'd5) begin bad++; $display("FAIL cont_cnt got=%0d want=5", retire_cnt); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3  [4] = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
    logic [1:0]  off [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      idle();
      lsu_valid   = 1'b1;
      lsu_rd      = 5'(10 + i);
      lsu_funct3  = f3[i];
      lsu_addr_lo = off[i];
      lsu_rdata   = 32'h80FF_7F01;
      #1;
      total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL ld_ready[%0d] got=%b want=1", i, lsu_ready); end
      cycle();
      total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(10 + i) || rf_wdata !== exp[i] || misalign_err !== 1'b0) begin
        bad++;
        $display("FAIL ld_ext[%0d] got=%b/%0d/%h/%b want=1/%0d/%h/0",
                 i, rf_wen, rf_waddr, rf_wdata, misalign_err, 10 + i, exp[i]);
      end
    end
    idle();
    total++; if (retire_cnt !== 64'd9) begin bad++; $display("FAIL ld_cnt got=%0d want=9", retire_cnt); end
  endtask

  task automatic test_misalign();
    idle();
    lsu_valid   = 1'b1;
    lsu_rd      = 5'd7;
    lsu_funct3  = F3_LW;
    lsu_addr_lo = 2'd1;
    lsu_rdata   = 32'h1234_5678;
    #1;
    total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL mis_ready got=%b want=1", lsu_ready); end
    cycle();
    lsu_funct3  = F3_LHU;
    lsu_rd      = 5'd8;
    lsu_addr_lo = 2'd3;
    total++; if (rf_wen !== 1'b0 || misalign_err !== 1'b1 || retire_cnt !== 64'd10) begin bad++;
      $display("FAIL mis_lw got wen=%b err=%b cnt=%0d want 0/1/10", rf_wen, misalign_err, retire_cnt); end
    total++; if (rf_waddr !== 5'd13 || rf_wdata !== 32'h0000_7F01) begin bad++;
      $display("FAIL mis_hold got=%0d/%h want=13/00007f01", rf_waddr, rf_wdata); end
    cycle();
    idle();
    total++; if (rf_wen !== 1'b0 || misalign_err !== 1'b1 || retire_cnt !== 64'd11) begin bad++;
      $display("FAIL mis_lhu got wen=%b err=%b cnt=%0d want 0/1/11", rf_wen, misalign_err, retire_cnt); end
    cycle();
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b want=0", misalign_err); end
  endtask

  task automatic test_rd_zero();
    idle();
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'h1234;
    cycle();
    idle();
    total++; if (rf_wen !== 1'b0 || rf_wdata !== 32'h0000_7F01 || retire_cnt !== 64'd12) begin bad++;
      $display("FAIL rd0 got wen=%b data=%h cnt=%0d want 0/00007f01/12", rf_wen, rf_wdata, retire_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
    idle();
    alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_rd   = 5'(20 + i);
      alu_data = vals[i];
      cycle();
      total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(20 + i) || rf_wdata !== vals[i]) begin bad++;
        $display("FAIL b2b[%0d] got=%b/%0d/%h want=1/%0d/%h", i, rf_wen, rf_waddr, rf_wdata, 20 + i, vals[i]); end
    end
    idle();
    total++; if (retire_cnt !== 64'd15) begin bad++; $display("FAIL b2b_cnt got=%0d want=15", retire_cnt); end
  endtask

  task automatic test_reset_mid();
    // Leave the pointer preferring the ALU, then reset with a transfer pending.
    idle();
    lsu_valid = 1'b1;
    lsu_rd    = 5'd9;
    lsu_rdata = 32'h5555_AAAA;
    cycle();
    idle();
    rst       = 1'b1;
    alu_valid = 1'b1;
    alu_rd    = 5'd4;
    alu_data  = 32'h0BAD_0BAD;
    cycle();
    rst = 1'b0;
    idle();
    total++; if (rf_wen !== 1'b0 || retire_cnt !== 64'd0 || rf_wdata !== 32'd0) begin bad++;
      $display("FAIL rst_mid got wen=%b cnt=%0d data=%h want 0/0/00000000", rf_wen, retire_cnt, rf_wdata); end
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd2;
    #1;
    total++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin bad++;
      $display("FAIL rst_pref got lsu=%b alu=%b want 1/0", lsu_ready, alu_ready); end
    cycle();
    idle();
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd2 || retire_cnt !== 64'd1) begin bad++;
      $display("FAIL rst_resume got=%b/%0d cnt=%0d want 1/2 cnt=1", rf_wen, rf_waddr, retire_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_alu_only();
    test_contention();
    test_load_extend();
    test_misalign();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
